// File: rtl/multiword_add_sub_seq.sv
// Multi-precision add/subtract sequencer.
// Streams one operand pair, LSW first, through a narrow external adder.
module multiword_add_sub_seq #(
  parameter int DATA_WD   = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WD*NUM_WORDS-1:0]   i_op_a,
  input  logic [DATA_WD*NUM_WORDS-1:0]   i_op_b,
  input  logic                           i_sub,
  output logic [DATA_WD-1:0]             o_add_a,
  output logic [DATA_WD-1:0]             o_add_b,
  output logic                           o_add_c,
  input  logic [DATA_WD:0]               i_add_out,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WD*NUM_WORDS-1:0]   o_result,
  output logic                           o_carry,
  output logic                           o_overflow
);

  localparam int TOT_WD = DATA_WD * NUM_WORDS;
  localparam int IDX_WD = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_WD-1:0] LAST = IDX_WD'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WORDS-1:0][DATA_WD-1:0] a_q;
  logic [NUM_WORDS-1:0][DATA_WD-1:0] b_q;
  logic [NUM_WORDS-1:0][DATA_WD-1:0] res_q;
  logic                              carry_q;
  logic [IDX_WD-1:0]                 idx_q;
  logic                              cout_q;
  logic                              ovf_q;
  logic                              last;
  logic                              ovf_d;

  assign last = (idx_q == LAST);

  // Signed overflow: like-signed operands (after B inversion) giving an
  // opposite-signed sum, taken from the final word's top sum bit.
  assign ovf_d =
    (a_q[NUM_WORDS-1][DATA_WD-1] == b_q[NUM_WORDS-1][DATA_WD-1]) &&
    (i_add_out[DATA_WD-1] != a_q[NUM_WORDS-1][DATA_WD-1]);

  always_comb begin
    state_d = state_q;
    o_add_a = '0;
    o_add_b = '0;
    o_add_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) state_d = RUN;
      end
      RUN: begin
        o_add_a = a_q[idx_q];
        o_add_b = b_q[idx_q];
        o_add_c = carry_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_op_a;
            b_q     <= i_sub ? ~i_op_b : i_op_b;
            carry_q <= i_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q[idx_q] <= i_add_out[DATA_WD-1:0];
          carry_q      <= i_add_out[DATA_WD];
          if (last) begin
            cout_q <= i_add_out[DATA_WD];
            ovf_q  <= ovf_d;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_result   = TOT_WD'(res_q);
  assign o_carry    = cout_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_sub_seq.sv
// Bench for multiword_add_sub_seq with a behavioural 4-bit adder.
// Table vectors, directed corner sequences and random ops vs a model.
module tb_multiword_add_sub_seq;

  localparam int DW = 4;
  localparam int NW = 4;
  localparam int TW = DW * NW;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [TW-1:0] i_op_a;
  logic [TW-1:0] i_op_b;
  logic          i_sub;
  logic [DW-1:0] o_add_a;
  logic [DW-1:0] o_add_b;
  logic          o_add_c;
  logic [DW:0]   i_add_out;
  logic          o_valid;
  logic          i_ready;
  logic [TW-1:0] o_result;
  logic          o_carry;
  logic          o_overflow;

  multiword_add_sub_seq #(.DATA_WD(DW), .NUM_WORDS(NW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_sub(i_sub),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_c(o_add_c),
    .i_add_out(i_add_out),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_carry(o_carry), .o_overflow(o_overflow)
  );

  // Downstream ripple adder behaviour
  assign i_add_out = {1'b0, o_add_a} + {1'b0, o_add_b} + {{DW{1'b0}}, o_add_c};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] seq_a [NW];
  logic [DW-1:0] seq_b [NW];
  logic          seq_c [NW];

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic [TW-1:0] res;
    logic          c;
    logic          ov;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  task automatic model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input logic sub, output logic [TW-1:0] res,
                       output logic c, output logic ov);
    longint ua, ub, ur, sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 65535);
    end
    res = ur[TW-1:0];
    ov  = (sr > 32767) || (sr < -32768);
  endtask

  task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input logic sub, input logic [TW-1:0] er,
                       input logic ec, input logic eov, input int hold);
    int n;
    int runs;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_before_op", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_op_a  = a;
    i_op_b  = b;
    i_sub   = sub;
    i_ready = (hold == 0);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_op_a  = TW'($urandom);
    i_op_b  = TW'($urandom);
    i_sub   = 1'($urandom);
    runs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_valid) break;
      if (runs < NW) begin
        seq_a[runs] = o_add_a;
        seq_b[runs] = o_add_b;
        seq_c[runs] = o_add_c;
      end
      runs++;
    end
    check("run_cycles", runs, NW);
    check("valid", {31'd0, o_valid}, 32'd1);
    check("result", {16'd0, o_result}, {16'd0, er});
    check("carry", {31'd0, o_carry}, {31'd0, ec});
    check("overflow", {31'd0, o_overflow}, {31'd0, eov});
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        i_valid = 1'($urandom);
        i_op_a  = TW'($urandom);
        @(negedge i_clk);
        check("hold_valid", {31'd0, o_valid}, 32'd1);
        check("hold_ready", {31'd0, o_ready}, 32'd0);
        check("hold_result", {16'd0, o_result}, {16'd0, er});
        check("hold_flags", {30'd0, o_carry, o_overflow}, {30'd0, ec, eov});
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
    @(negedge i_clk);
    check("valid_drop", {31'd0, o_valid}, 32'd0);
    check("ready_back", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [TW-1:0] mr;
    logic          mc;
    logic          mov;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rs;

    tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_op_a  = '0;
    i_op_b  = '0;
    i_sub   = 1'b0;
    i_ready = 1'b1;
    #3;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", {16'd0, o_result}, 32'd0);
    check("rst_flags", {30'd0, o_carry, o_overflow}, 32'd0);
    check("rst_adder", {23'd0, o_add_a, o_add_b, o_add_c}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub,
            tbl[i].res, tbl[i].c, tbl[i].ov, 0);
      if (i == 0) begin
        check("seq_a", {16'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]},
              32'h4321);
      end
      if (i == 1) begin
        check("seq_c", {28'd0, seq_c[0], seq_c[1], seq_c[2], seq_c[3]},
              32'b0111);
      end
      if (i == 2) begin
        check("sub_b0", {28'd0, seq_b[0]}, 32'h8);
        check("sub_c0", {31'd0, seq_c[0]}, 32'd1);
      end
    end

    // Backpressure then a follow-up op
    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 10);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Asynchronous reset with the op at word index 2
    @(negedge i_clk);
    i_valid = 1'b1;
    i_op_a  = 16'h1111;
    i_op_b  = 16'h2222;
    i_sub   = 1'b0;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("mid_run_partial", {16'd0, o_result}, 32'h0033);
    check("mid_run_add_a", {28'd0, o_add_a}, 32'h1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_result", {16'd0, o_result}, 32'd0);
    check("arst_adder", {23'd0, o_add_a, o_add_b, o_add_c}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    // Random ops against the arithmetic model
    for (int r = 0; r < 25; r++) begin
      ra = TW'($urandom);
      rb = TW'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, mr, mc, mov);
      do_op(ra, rb, rs, mr, mc, mov, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
